// File: rtl/condicionador_entradas.sv
// Input conditioner: synchronizes and debounces the start button and the switch bank,
// then turns them into a one-cycle start pulse and a one-shot "jogada" pulse with capture.
module condicionador_entradas #(
    parameter int unsigned DEBOUNCE = 4  // consecutive stable cycles to accept a change (1..65535)
) (
    input  logic       clock,              // single system clock, rising edge
    input  logic       reset,              // asynchronous, active-high
    input  logic       iniciar_bruto,      // raw asynchronous start button
    input  logic [3:0] chaves_brutas,      // raw asynchronous switch/button bank
    output logic       iniciar_pulso,      // one-cycle start pulse
    output logic       jogada_pulso,       // one-cycle new-press pulse
    output logic [3:0] chaves_registradas, // switch snapshot taken at the last jogada
    output logic [3:0] db_chaves_estaveis  // debounced switch levels
);

    localparam int NB = 5;
    localparam int unsigned CW = $clog2(DEBOUNCE) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        StArmado    = 2'd0,
        StPulso     = 2'd1,
        StSegurando = 2'd2
    } estado_e;

    // Bit 4 is iniciar, bits 3:0 are the switches.
    logic [NB-1:0] bruto;
    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] estavel_q;
    logic [NB-1:0] estavel_d;
    logic [CW-1:0] cnt_q [NB];
    logic [CW-1:0] cnt_d [NB];

    logic          iniciar_ant_q;
    logic          iniciar_pulso_q;
    logic [3:0]    chaves_reg_q;
    logic [3:0]    db_chaves;
    logic          algum_pressionado;
    estado_e       estado_q;
    estado_e       estado_d;

    assign bruto = {iniciar_bruto, chaves_brutas};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bruto;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: a disagreement must persist DEBOUNCE cycles before it is accepted.
    always_comb begin
        estavel_d = estavel_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != estavel_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    estavel_d[i] = sync2_q[i];
                    cnt_d[i]     = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estavel_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            estavel_q <= estavel_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign db_chaves         = estavel_q[3:0];
    assign algum_pressionado = |db_chaves;

    // Rising-edge detect on the stable start level, registered one cycle later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iniciar_ant_q   <= 1'b0;
            iniciar_pulso_q <= 1'b0;
        end else begin
            iniciar_ant_q   <= estavel_q[4];
            iniciar_pulso_q <= estavel_q[4] & ~iniciar_ant_q;
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StArmado:    if (algum_pressionado) estado_d = StPulso;
            StPulso:     estado_d = algum_pressionado ? StSegurando : StArmado;
            StSegurando: if (!algum_pressionado) estado_d = StArmado;
            default:     estado_d = StArmado;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= StArmado;
            chaves_reg_q <= '0;
        end else begin
            estado_q <= estado_d;
            // Capture only on entry into StPulso, which is reachable only from StArmado.
            if (estado_q == StArmado && algum_pressionado) begin
                chaves_reg_q <= db_chaves;
            end
        end
    end

    assign iniciar_pulso      = iniciar_pulso_q;
    assign jogada_pulso       = (estado_q == StPulso);
    assign chaves_registradas = chaves_reg_q;
    assign db_chaves_estaveis = db_chaves;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Directed bench for condicionador_entradas with DEBOUNCE=4: inputs change just after an
// edge, so the following edge is sample edge 1; outputs are checked 1 time unit after each edge.
module tb_condicionador_entradas;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar_bruto;
    logic [3:0] chaves_brutas;
    logic       iniciar_pulso;
    logic       jogada_pulso;
    logic [3:0] chaves_registradas;
    logic [3:0] db_chaves_estaveis;

    int errors = 0;
    int checks = 0;

    condicionador_entradas #(.DEBOUNCE(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar_bruto      (iniciar_bruto),
        .chaves_brutas      (chaves_brutas),
        .iniciar_pulso      (iniciar_pulso),
        .jogada_pulso       (jogada_pulso),
        .chaves_registradas (chaves_registradas),
        .db_chaves_estaveis (db_chaves_estaveis)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        iniciar_bruto = 1'b0;
        chaves_brutas = 4'b0000;
        repeat (12) tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        iniciar_bruto = 1'b0;
        chaves_brutas = 4'b0000;
        repeat (3) tick();
        checks++;
        if ({iniciar_pulso, jogada_pulso, chaves_registradas, db_chaves_estaveis} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {iniciar_pulso, jogada_pulso, chaves_registradas, db_chaves_estaveis}, 10'b0);
        end
        reset = 1'b0;
        tick();
    endtask

    // Rise sampled at edge 1 -> pulse only after edge 1+2+4 = 7; held high gives no more.
    task automatic test_iniciar;
        iniciar_bruto = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            tick();
            checks++;
            if (iniciar_pulso !== (e == 7)) begin
                errors++;
                $display("FAIL iniciar_pulse edge %0d: got %b expected %b", e, iniciar_pulso, e == 7);
            end
        end
        iniciar_bruto = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (iniciar_pulso !== 1'b0) begin
                errors++;
                $display("FAIL iniciar_release edge %0d: got %b expected 0", e, iniciar_pulso);
            end
        end
    endtask

    task automatic test_glitch;
        iniciar_bruto = 1'b1;
        chaves_brutas = 4'b0010;
        repeat (3) tick();
        iniciar_bruto = 1'b0;
        chaves_brutas = 4'b0000;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (iniciar_pulso !== 1'b0 || jogada_pulso !== 1'b0 || db_chaves_estaveis !== 4'b0) begin
                errors++;
                $display("FAIL glitch edge %0d: got ini=%b jog=%b db=%b expected 0 0 0000",
                         e, iniciar_pulso, jogada_pulso, db_chaves_estaveis);
            end
        end
    endtask

    task automatic test_jogada;
        logic [3:0] exp_db;
        logic [3:0] exp_reg;
        chaves_brutas = 4'b0100;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_db  = (e >= 6) ? 4'b0100 : 4'b0000;
            exp_reg = (e >= 7) ? 4'b0100 : 4'b0000;
            checks++;
            if (jogada_pulso !== (e == 7) || db_chaves_estaveis !== exp_db ||
                chaves_registradas !== exp_reg) begin
                errors++;
                $display("FAIL jogada_0100 edge %0d: got jog=%b db=%b reg=%b expected %b %b %b",
                         e, jogada_pulso, db_chaves_estaveis, chaves_registradas, e == 7, exp_db,
                         exp_reg);
            end
        end
        chaves_brutas = 4'b0110;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (jogada_pulso !== 1'b0 || chaves_registradas !== 4'b0100) begin
                errors++;
                $display("FAIL jogada_0110 edge %0d: got jog=%b reg=%b expected 0 0100",
                         e, jogada_pulso, chaves_registradas);
            end
        end
        checks++;
        if (db_chaves_estaveis !== 4'b0110) begin
            errors++;
            $display("FAIL db_0110: got %b expected 0110", db_chaves_estaveis);
        end
        chaves_brutas = 4'b0000;
        repeat (12) tick();
        checks++;
        if (db_chaves_estaveis !== 4'b0000 || chaves_registradas !== 4'b0100) begin
            errors++;
            $display("FAIL release: got db=%b reg=%b expected 0000 0100",
                     db_chaves_estaveis, chaves_registradas);
        end
        chaves_brutas = 4'b1000;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_reg = (e >= 7) ? 4'b1000 : 4'b0100;
            checks++;
            if (jogada_pulso !== (e == 7) || chaves_registradas !== exp_reg) begin
                errors++;
                $display("FAIL jogada_1000 edge %0d: got jog=%b reg=%b expected %b %b",
                         e, jogada_pulso, chaves_registradas, e == 7, exp_reg);
            end
        end
    endtask

    task automatic test_same_edge;
        int pulsos;
        settle();
        pulsos = 0;
        chaves_brutas = 4'b0011;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (jogada_pulso === 1'b1) pulsos++;
        end
        checks++;
        if (pulsos != 1 || chaves_registradas !== 4'b0011) begin
            errors++;
            $display("FAIL same_edge: got pulses=%0d reg=%b expected 1 0011",
                     pulsos, chaves_registradas);
        end
    endtask

    // Bit 1 qualifies one edge after bit 0, while already in the pulse state.
    task automatic test_staggered;
        int pulsos;
        settle();
        pulsos = 0;
        chaves_brutas = 4'b0001;
        tick();
        if (jogada_pulso === 1'b1) pulsos++;
        chaves_brutas = 4'b0011;
        for (int e = 2; e <= 14; e++) begin
            tick();
            if (jogada_pulso === 1'b1) pulsos++;
        end
        checks++;
        if (pulsos != 1 || chaves_registradas !== 4'b0001 || db_chaves_estaveis !== 4'b0011) begin
            errors++;
            $display("FAIL staggered: got pulses=%0d reg=%b db=%b expected 1 0001 0011",
                     pulsos, chaves_registradas, db_chaves_estaveis);
        end
    endtask

    task automatic test_reset_mid;
        settle();
        iniciar_bruto = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({iniciar_pulso, jogada_pulso, chaves_registradas, db_chaves_estaveis} !== 10'b0) begin
            errors++;
            $display("FAIL reset_mid_count: got %b expected %b",
                     {iniciar_pulso, jogada_pulso, chaves_registradas, db_chaves_estaveis}, 10'b0);
        end
        repeat (2) tick();
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (iniciar_pulso !== (e == 7)) begin
                errors++;
                $display("FAIL reset_requalify edge %0d: got %b expected %b",
                         e, iniciar_pulso, e == 7);
            end
        end
        // Reset while jogada_pulso is high, switch still held afterwards.
        settle();
        chaves_brutas = 4'b0010;
        repeat (7) tick();
        checks++;
        if (jogada_pulso !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pulse: got %b expected 1", jogada_pulso);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (jogada_pulso !== 1'b0 || chaves_registradas !== 4'b0 || db_chaves_estaveis !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid_pulse: got jog=%b reg=%b db=%b expected 0 0000 0000",
                     jogada_pulso, chaves_registradas, db_chaves_estaveis);
        end
        repeat (2) tick();
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (jogada_pulso !== (e == 7) || chaves_registradas !== ((e >= 7) ? 4'b0010 : 4'b0)) begin
                errors++;
                $display("FAIL reset_held_switch edge %0d: got jog=%b reg=%b expected %b %b",
                         e, jogada_pulso, chaves_registradas, e == 7,
                         (e >= 7) ? 4'b0010 : 4'b0000);
            end
        end
    endtask

    task automatic test_simultaneous;
        settle();
        iniciar_bruto = 1'b1;
        chaves_brutas = 4'b0001;
        for (int e = 1; e <= 12; e++) begin
            tick();
            checks++;
            if (iniciar_pulso !== (e == 7) || jogada_pulso !== (e == 7)) begin
                errors++;
                $display("FAIL simultaneous edge %0d: got ini=%b jog=%b expected %b %b",
                         e, iniciar_pulso, jogada_pulso, e == 7, e == 7);
            end
        end
        checks++;
        if (chaves_registradas !== 4'b0001) begin
            errors++;
            $display("FAIL simultaneous_capture: got %b expected 0001", chaves_registradas);
        end
    endtask

    initial begin
        test_reset();
        test_iniciar();
        test_glitch();
        test_jogada();
        test_same_edge();
        test_staggered();
        test_reset_mid();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
